// File: rtl/rr_buf_arbiter.sv
// ============================================================================
// rr_buf_arbiter : round-robin arbiter with burst limit feeding one output reg
// Revision      : 1.0
// ============================================================================
`default_nettype none

module rr_buf_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 1,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_WIDTH-1:0]           out_id,
    input  logic                          out_ready
);

    localparam logic [7:0]          C_MAX_BURST = 8'(MAX_BURST);
    localparam logic [ID_WIDTH-1:0] C_LAST_IDX  = ID_WIDTH'(NUM_REQ - 1);

    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [7:0]            burst_cnt_q, burst_cnt_d;
    logic [ID_WIDTH-1:0]   last_id_q, last_id_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;

    logic [DATA_WIDTH-1:0] w_words [NUM_REQ];
    logic [ID_WIDTH-1:0]   w_grant;
    logic                  w_any;
    logic                  w_can_load;
    logic                  w_xfer;
    logic [7:0]            w_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Rotating search: first valid requester at or after ptr, wrapping around.
    always_comb begin
        int idx;
        w_any   = 1'b0;
        w_grant = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_any && req_valid[ID_WIDTH'(idx)]) begin
                w_any   = 1'b1;
                w_grant = ID_WIDTH'(idx);
            end
        end
    end

    assign w_can_load = !out_valid_q || out_ready;
    assign w_xfer     = w_any && w_can_load && !rst;
    assign req_ready  = w_xfer ? (NUM_REQ'(1) << w_grant) : '0;

    assign w_cnt_next = (w_grant == last_id_q && burst_cnt_q != 8'd0) ?
                        burst_cnt_q + 8'd1 : 8'd1;

    always_comb begin
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        last_id_d   = last_id_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (w_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = w_words[w_grant];
            out_id_d    = w_grant;
            last_id_d   = w_grant;
            if (w_cnt_next == C_MAX_BURST) begin
                ptr_d       = (w_grant == C_LAST_IDX) ? '0 : w_grant + ID_WIDTH'(1);
                burst_cnt_d = 8'd0;
            end else begin
                ptr_d       = w_grant;
                burst_cnt_d = w_cnt_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            burst_cnt_q <= '0;
            last_id_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
            last_id_q   <= last_id_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_buf_arbiter.sv
// ============================================================================
// tb_rr_buf_arbiter : scoreboard bench, pure round-robin and burst-3 instances
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_rr_buf_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] v1, v3, rr1, rr3;
    logic [NR*DW-1:0] d1, d3;
    logic          or1, or3, ov1, ov3;
    logic [DW-1:0] od1, od3;
    logic [1:0]    oid1, oid3;

    int checks = 0;
    int errors = 0;
    logic [9:0] q1[$];
    logic [9:0] q3[$];

    always #5 clk = ~clk;

    rr_buf_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_data(d1), .req_ready(rr1),
        .out_valid(ov1), .out_data(od1), .out_id(oid1), .out_ready(or1));

    rr_buf_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(3)) u3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_data(d3), .req_ready(rr3),
        .out_valid(ov3), .out_data(od3), .out_id(oid3), .out_ready(or3));

    // Monitors: every accepted output word is matched against the queue head.
    always @(negedge clk) begin
        logic [9:0] e;
        if (ov1 && or1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL u1_out unexpected word actual id=%0d data=%0h required none", oid1, od1);
            end else begin
                e = q1.pop_front();
                if ({oid1, od1} !== e) begin
                    errors++;
                    $display("FAIL u1_out actual id=%0d data=%0h required id=%0d data=%0h",
                             oid1, od1, e[9:8], e[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (ov3 && or3) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL u3_out unexpected word actual id=%0d data=%0h required none", oid3, od3);
            end else begin
                e = q3.pop_front();
                if ({oid3, od3} !== e) begin
                    errors++;
                    $display("FAIL u3_out actual id=%0d data=%0h required id=%0d data=%0h",
                             oid3, od3, e[9:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; v1 = 4'b1111; v3 = '0; d1 = '0; d3 = '0; or1 = 1'b1; or3 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(rr1), 32'h0);
        chk("rst_out_valid", 32'(ov1), 32'h0);
        chk("rst_out_id",    32'(oid1), 32'h0);
        chk("rst_out_data",  32'(od1), 32'h0);

        // Pure round-robin over all four requesters
        d1 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 8; i++) q1.push_back({2'(i % 4), 8'hA0 + 8'(i % 4)});
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("first_grant", 32'(rr1), 32'h1);
        @(posedge clk); #1;
        repeat (7) tick();
        v1 = '0;
        tick();
        chk("rr_drained_q", 32'(q1.size()), 32'h0);
        chk("rr_out_valid_idle", 32'(ov1), 32'h0);

        // Burst limit of three between requesters 1 and 2
        v3 = 4'b0110;
        d3 = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        q3.push_back({2'd1, 8'hB1}); q3.push_back({2'd1, 8'hB1}); q3.push_back({2'd1, 8'hB1});
        q3.push_back({2'd2, 8'hB2}); q3.push_back({2'd2, 8'hB2}); q3.push_back({2'd2, 8'hB2});
        q3.push_back({2'd1, 8'hB1}); q3.push_back({2'd1, 8'hB1}); q3.push_back({2'd1, 8'hB1});
        repeat (9) tick();
        v3 = '0;
        tick();
        chk("burst_drained_q", 32'(q3.size()), 32'h0);

        // Backpressure hold, then drain-and-load in the same cycle
        or1 = 1'b0; v1 = 4'b0100; d1 = {8'h00, 8'h55, 8'h00, 8'h00};
        q1.push_back({2'd2, 8'h55}); q1.push_back({2'd2, 8'h66});
        tick();
        d1 = {8'h00, 8'h66, 8'h00, 8'h00};
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", 32'(ov1), 32'h1);
            chk("hold_data",  32'(od1), 32'h55);
            chk("hold_id",    32'(oid1), 32'h2);
            chk("hold_ready", 32'(rr1), 32'h0);
        end
        @(posedge clk); #1 or1 = 1'b1;
        #1 chk("release_ready", 32'(rr1), 32'h4);
        @(posedge clk); #1 v1 = '0;
        chk("no_bubble_valid", 32'(ov1), 32'h1);
        chk("no_bubble_data",  32'(od1), 32'h66);
        tick();
        chk("bp_drained_q", 32'(q1.size()), 32'h0);

        // Sparse 3/0 with wrap, then a granted requester that drops valid
        d1 = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        v1 = 4'b1001;
        q1.push_back({2'd3, 8'hC3}); q1.push_back({2'd0, 8'hC0});
        q1.push_back({2'd3, 8'hC3}); q1.push_back({2'd0, 8'hC0});
        repeat (4) tick();
        v1 = 4'b0100;
        #1 chk("drop_granted", 32'(rr1), 32'h4);
        v1 = '0;
        tick();
        chk("drop_no_xfer", 32'(ov1), 32'h0);
        v1 = 4'b1011;
        q1.push_back({2'd1, 8'hC1});
        tick();
        v1 = '0;
        tick();
        chk("sparse_drained_q", 32'(q1.size()), 32'h0);

        // Asynchronous reset while a word is held
        or1 = 1'b0; v1 = 4'b0010;
        tick();
        v1 = 4'b0110;
        @(negedge clk);
        chk("pre_rst_valid", 32'(ov1), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(ov1), 32'h0);
        chk("async_rst_ready", 32'(rr1), 32'h0);
        chk("async_rst_data",  32'(od1), 32'h0);
        @(posedge clk); #1 rst = 1'b0; or1 = 1'b1;
        q1.push_back({2'd1, 8'hC1});
        #1 chk("post_rst_grant", 32'(rr1), 32'h2);
        tick();
        v1 = '0;
        tick();
        chk("final_q1", 32'(q1.size()), 32'h0);
        chk("final_q3", 32'(q3.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
